// File: rtl/signed_calc_pkg.sv
// Shared FSM type, BCD sizing and active-low 7-segment (gfedcba) constants for the
// signed BCD display path.
package signed_calc_pkg;

   typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} state_e;

   localparam int BCD_W  = 4;
   localparam int DIGITS = 3;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_MINUS = 7'h3F;
   localparam logic [6:0] SEG_LUT [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   function automatic logic [BCD_W-1:0] dabble_adj(input logic [BCD_W-1:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   // Codes above 9 never occur after a valid conversion; show them blank.
   function automatic logic [6:0] seg_lookup(input logic [BCD_W-1:0] d);
      return (d <= 4'd9) ? SEG_LUT[d] : SEG_BLANK;
   endfunction

endpackage

// File: rtl/signed_bcd_disp_v_if.sv
// Request/result bundle of the signed BCD converter.
// Segment signals exist only when SIGNED_BCD_SEG_EN is defined.
interface signed_bcd_disp_v_if #(
   parameter int IN_W = 9
);
   logic                   i_start;
   logic signed [IN_W-1:0] i_fs;
   logic                   o_busy;
   logic                   o_done;
   logic                   o_neg;
   logic [3:0]             o_hund;
   logic [3:0]             o_tens;
   logic [3:0]             o_ones;
`ifdef SIGNED_BCD_SEG_EN
   logic [6:0]             o_seg_sign;
   logic [6:0]             o_seg_hund;
   logic [6:0]             o_seg_tens;
   logic [6:0]             o_seg_ones;

   modport master (
      output i_start, i_fs,
      input  o_busy, o_done, o_neg, o_hund, o_tens, o_ones,
      input  o_seg_sign, o_seg_hund, o_seg_tens, o_seg_ones
   );
   modport slave (
      input  i_start, i_fs,
      output o_busy, o_done, o_neg, o_hund, o_tens, o_ones,
      output o_seg_sign, o_seg_hund, o_seg_tens, o_seg_ones
   );
`else
   modport master (
      output i_start, i_fs,
      input  o_busy, o_done, o_neg, o_hund, o_tens, o_ones
   );
   modport slave (
      input  i_start, i_fs,
      output o_busy, o_done, o_neg, o_hund, o_tens, o_ones
   );
`endif
endinterface

// File: rtl/bcd_to_7seg_v.sv
// Registered BCD digit to active-low 7-segment (gfedcba) decoder.
// Instantiated only when SIGNED_BCD_SEG_EN is defined.
module bcd_to_7seg_v
   import signed_calc_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [BCD_W-1:0] i_digit,
   output logic [6:0]       o_seg
);

   logic [6:0] r_seg;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_seg <= SEG_BLANK;
      end else begin
         r_seg <= seg_lookup(i_digit);
      end
   end

   assign o_seg = r_seg;

endmodule

// File: rtl/signed_bcd_disp_v.sv
// Signed two's-complement to sign + 3-digit BCD converter using serial double dabble.
// Define SIGNED_BCD_SEG_EN to add registered active-low 7-segment outputs.
module signed_bcd_disp_v
   import signed_calc_pkg::*;
#(
   parameter int IN_W = 9
) (
   input  logic                i_clk,
   input  logic                i_rst,
   signed_bcd_disp_v_if.slave  io_bus
);

   localparam int         SCR_W    = BCD_W * DIGITS;
   localparam logic [3:0] CNT_LAST = 4'(IN_W);

   state_e             r_state;
   logic [IN_W-1:0]    r_fs;
   logic [IN_W:0]      r_mag;
   logic [SCR_W-1:0]   r_scr;
   logic [3:0]         r_cnt;
   logic               r_sign;
   logic               r_busy;
   logic               r_done;
   logic               r_neg;
   logic [BCD_W-1:0]   r_hund;
   logic [BCD_W-1:0]   r_tens;
   logic [BCD_W-1:0]   r_ones;

   logic [IN_W:0]      w_fs_ext;
   logic [IN_W:0]      w_mag;
   logic [SCR_W-1:0]   w_adj;
   logic [SCR_W-1:0]   w_scr_nxt;

   // One extra magnitude bit keeps -2^(IN_W-1) exact after negation.
   assign w_fs_ext  = {r_fs[IN_W-1], r_fs};
   assign w_mag     = r_fs[IN_W-1] ? (~w_fs_ext + {{IN_W{1'b0}}, 1'b1}) : w_fs_ext;
   assign w_scr_nxt = {w_adj[SCR_W-2:0], r_mag[IN_W]};

   always_comb begin
      w_adj = r_scr;
      for (int d = 0; d < DIGITS; d++) begin
         w_adj[d*BCD_W +: BCD_W] = dabble_adj(r_scr[d*BCD_W +: BCD_W]);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
         r_fs    <= '0;
         r_mag   <= '0;
         r_scr   <= '0;
         r_cnt   <= '0;
         r_sign  <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_neg   <= 1'b0;
         r_hund  <= '0;
         r_tens  <= '0;
         r_ones  <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            StIdle: begin
               if (io_bus.i_start) begin
                  r_fs    <= io_bus.i_fs;
                  r_busy  <= 1'b1;
                  r_state <= StLoad;
               end
            end
            StLoad: begin
               r_sign  <= r_fs[IN_W-1];
               r_mag   <= w_mag;
               r_scr   <= '0;
               r_cnt   <= '0;
               r_state <= StShift;
            end
            StShift: begin
               r_scr <= w_scr_nxt;
               // Bit leaving the scratch refills the spent magnitude; it is always 0 in range.
               r_mag <= {r_mag[IN_W-1:0], w_adj[SCR_W-1]};
               if (r_cnt == CNT_LAST) begin
                  r_state <= StDone;
                  r_done  <= 1'b1;
                  r_neg   <= r_sign;
                  r_hund  <= w_scr_nxt[2*BCD_W +: BCD_W];
                  r_tens  <= w_scr_nxt[BCD_W +: BCD_W];
                  r_ones  <= w_scr_nxt[0 +: BCD_W];
               end else begin
                  r_cnt <= r_cnt + 4'd1;
               end
            end
            StDone: begin
               r_busy  <= 1'b0;
               r_state <= StIdle;
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_bus.o_busy = r_busy;
   assign io_bus.o_done = r_done;
   assign io_bus.o_neg  = r_neg;
   assign io_bus.o_hund = r_hund;
   assign io_bus.o_tens = r_tens;
   assign io_bus.o_ones = r_ones;

`ifdef SIGNED_BCD_SEG_EN
   logic [6:0] r_seg_sign;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_seg_sign <= SEG_BLANK;
      end else begin
         r_seg_sign <= r_neg ? SEG_MINUS : SEG_BLANK;
      end
   end

   assign io_bus.o_seg_sign = r_seg_sign;

   bcd_to_7seg_v u_seg_hund (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_digit (r_hund),
      .o_seg   (io_bus.o_seg_hund)
   );

   bcd_to_7seg_v u_seg_tens (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_digit (r_tens),
      .o_seg   (io_bus.o_seg_tens)
   );

   bcd_to_7seg_v u_seg_ones (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_digit (r_ones),
      .o_seg   (io_bus.o_seg_ones)
   );
`endif

endmodule

// File: tb/tb_signed_bcd_disp_v.sv
// Directed self-checking bench for signed_bcd_disp_v (segment checks when SIGNED_BCD_SEG_EN).
module tb_signed_bcd_disp_v;

   localparam int IN_W = 9;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   signed_bcd_disp_v_if #(.IN_W(IN_W)) bus ();

   signed_bcd_disp_v #(.IN_W(IN_W)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .io_bus (bus)
   );

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Starts a conversion from IDLE, checks latency and result, and returns in the IDLE cycle.
   task automatic run_conv(input string tag, input int val, input int en,
                           input int eh, input int et, input int eo);
      int cyc;
      int done_at;
      bus.i_fs    = val[IN_W-1:0];
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      check_eq({tag, "_busy"}, int'(bus.o_busy), 1);
      cyc     = 1;
      done_at = -1;
      while (cyc <= 30 && done_at < 0) begin
         if (bus.o_done) done_at = cyc;
         else begin
            tick();
            cyc++;
         end
      end
      check_eq({tag, "_lat"}, done_at, 12);
      check_eq({tag, "_neg"}, int'(bus.o_neg), en);
      check_eq({tag, "_hund"}, int'(bus.o_hund), eh);
      check_eq({tag, "_tens"}, int'(bus.o_tens), et);
      check_eq({tag, "_ones"}, int'(bus.o_ones), eo);
      tick();
      check_eq({tag, "_idle"}, int'(bus.o_busy), 0);
      check_eq({tag, "_done1"}, int'(bus.o_done), 0);
   endtask

   initial begin
      int n_done;
      int first;
      int d1;
      int d2;
      int nv [2];
      int dg [2][3];

      rst         = 1'b1;
      bus.i_start = 1'b1;
      bus.i_fs    = 9'sd5;
      tick();
      tick();
      check_eq("rst_prio_busy", int'(bus.o_busy), 0);
      bus.i_start = 1'b0;
      rst         = 1'b0;
      tick();
      check_eq("rst_busy", int'(bus.o_busy), 0);
      check_eq("rst_done", int'(bus.o_done), 0);
      check_eq("rst_neg", int'(bus.o_neg), 0);
      check_eq("rst_digits", int'({bus.o_hund, bus.o_tens, bus.o_ones}), 0);

      run_conv("zero", 0, 0, 0, 0, 0);
      run_conv("m225", -225, 1, 2, 2, 5);
      tick();
      tick();
      check_eq("hold_ones", int'(bus.o_ones), 5);
      check_eq("hold_neg", int'(bus.o_neg), 1);
      run_conv("m256", -256, 1, 2, 5, 6);
      run_conv("m1", -1, 1, 0, 0, 1);

      // Extra start pulses mid-conversion must be ignored, including their i_fs.
      bus.i_fs    = 9'sd255;
      bus.i_start = 1'b1;
      tick();
      n_done = 0;
      first  = -1;
      for (int cyc = 1; cyc <= 25; cyc++) begin
         if (bus.o_done) begin
            n_done++;
            if (first < 0) first = cyc;
            check_eq("p255_hund", int'(bus.o_hund), 2);
            check_eq("p255_tens", int'(bus.o_tens), 5);
            check_eq("p255_ones", int'(bus.o_ones), 5);
            check_eq("p255_neg", int'(bus.o_neg), 0);
         end
         bus.i_start = (cyc == 3 || cyc == 8);
         bus.i_fs    = 9'sd7;
         tick();
      end
      check_eq("p255_ndone", n_done, 1);
      check_eq("p255_lat", first, 12);

      // Reset during the fifth SHIFT cycle (cycle 6) aborts silently.
      bus.i_fs    = 9'sd3;
      bus.i_start = 1'b1;
      tick();
      bus.i_start = 1'b0;
      n_done = 0;
      for (int cyc = 1; cyc <= 20; cyc++) begin
         if (bus.o_done) n_done++;
         if (cyc == 5) check_eq("abort_busy_pre", int'(bus.o_busy), 1);
         rst = (cyc == 6);
         tick();
      end
      rst = 1'b0;
      check_eq("abort_ndone", n_done, 0);
      check_eq("abort_busy", int'(bus.o_busy), 0);
      check_eq("abort_neg", int'(bus.o_neg), 0);
      check_eq("abort_digits", int'({bus.o_hund, bus.o_tens, bus.o_ones}), 0);
      run_conv("p45", 45, 0, 0, 4, 5);

      // Held start: back-to-back conversions, second one captures the changed i_fs.
      bus.i_fs    = 9'sd100;
      bus.i_start = 1'b1;
      tick();
      d1 = -1;
      d2 = -1;
      for (int cyc = 1; cyc <= 27; cyc++) begin
         if (bus.o_done) begin
            if (d1 < 0) begin
               d1 = cyc;
               nv[0] = int'(bus.o_neg);
               dg[0][0] = int'(bus.o_hund);
               dg[0][1] = int'(bus.o_tens);
               dg[0][2] = int'(bus.o_ones);
            end else if (d2 < 0) begin
               d2 = cyc;
               nv[1] = int'(bus.o_neg);
               dg[1][0] = int'(bus.o_hund);
               dg[1][1] = int'(bus.o_tens);
               dg[1][2] = int'(bus.o_ones);
            end
         end
         if (cyc == 1) bus.i_fs = -9'sd37;
         tick();
      end
      bus.i_start = 1'b0;
      check_eq("b2b_first", d1, 12);
      check_eq("b2b_period", d2 - d1, 13);
      if (d1 > 0) begin
         check_eq("b2b1_neg", nv[0], 0);
         check_eq("b2b1_digits", dg[0][0] * 100 + dg[0][1] * 10 + dg[0][2], 100);
      end
      if (d2 > 0) begin
         check_eq("b2b2_neg", nv[1], 1);
         check_eq("b2b2_digits", dg[1][0] * 100 + dg[1][1] * 10 + dg[1][2], 37);
      end
      for (int i = 0; i < 20; i++) tick();
      check_eq("b2b_idle", int'(bus.o_busy), 0);

`ifdef SIGNED_BCD_SEG_EN
      run_conv("m8", -8, 1, 0, 0, 8);
      check_eq("seg_ones", int'(bus.o_seg_ones), 'h00);
      check_eq("seg_sign", int'(bus.o_seg_sign), 'h3F);
      check_eq("seg_hund", int'(bus.o_seg_hund), 'h40);
      check_eq("seg_tens", int'(bus.o_seg_tens), 'h40);
      run_conv("p95", 95, 0, 0, 9, 5);
      check_eq("seg_sign_pos", int'(bus.o_seg_sign), 'h7F);
      check_eq("seg_tens9", int'(bus.o_seg_tens), 'h10);
      check_eq("seg_ones5", int'(bus.o_seg_ones), 'h12);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/signed_bcd_disp_v.md
SIGNED_BCD_DISP_V -- requirements
Module: signed_bcd_disp_v

Interface
REQ-001 The module SHALL declare parameter IN_W, default 9, giving the width of the signed two's-complement result consumed; legal range is 2..10.
REQ-002 The module SHALL declare port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-003 The module SHALL declare port i_rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 The module SHALL declare port i_start, input, 1 bit, a request to convert i_fs.
REQ-005 The module SHALL declare port i_fs, input, IN_W bits signed, the result word from the upstream signed calculator.
REQ-006 The module SHALL declare port o_busy, output, 1 bit, high while a conversion is in progress.
REQ-007 The module SHALL declare port o_done, output, 1 bit, a one-cycle pulse marking new digits.
REQ-008 The module SHALL declare port o_neg, output, 1 bit, the sign of the last converted value.
REQ-009 The module SHALL declare ports o_hund, o_tens and o_ones, outputs, 4 bits each, the BCD magnitude digits.

Function
REQ-010 The module SHALL implement FSM states IDLE, LOAD, SHIFT and DONE.
REQ-011 In IDLE with i_start=1, the module SHALL capture i_fs at that edge and go to LOAD; i_start while not in IDLE SHALL be ignored.
REQ-012 In LOAD, the module SHALL register the sign bit and the magnitude, computed as |i_fs| zero-extended to IN_W+1 bits so that -2^(IN_W-1) is represented exactly, clear the BCD scratch, and go to SHIFT.
REQ-013 In SHIFT, the module SHALL perform one double-dabble step per cycle: add 3 to every scratch digit >=5, then shift left one bit taking the magnitude MSB.
REQ-014 The module SHALL stay in SHIFT for exactly IN_W+1 cycles, counted by a bit counter, then go to DONE.
REQ-015 In DONE, the module SHALL drive o_done=1 for exactly one cycle and return to IDLE.
REQ-016 The module SHALL update o_neg, o_hund, o_tens and o_ones on the same edge that enters DONE, and hold them until the next DONE.
REQ-017 Total latency SHALL be IN_W+3 cycles from the start edge to the o_done cycle; at IN_W=9 this is 12 cycles.
REQ-018 The module SHALL drive o_busy=1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-019 The module SHALL report zero as positive: o_neg=0 and digits 0,0,0.
REQ-020 With i_start held high, the module SHALL start a new conversion on the first IDLE cycle after DONE, giving back-to-back throughput of one conversion per IN_W+4 cycles.

Reset
REQ-021 On i_rst=1, at any state including mid-SHIFT, the module SHALL enter IDLE and abort any conversion without producing o_done.
REQ-022 On reset, the module SHALL clear o_busy, o_done, o_neg and all digits to 0, and clear the scratch and bit counter.
REQ-023 Reset SHALL take priority over i_start in the same cycle.

Configuration
REQ-024 When SIGNED_BCD_SEG_EN is defined, the module SHALL add outputs o_seg_sign, o_seg_hund, o_seg_tens and o_seg_ones, 7 bits each, active-low, segment order gfedcba.
REQ-025 With SIGNED_BCD_SEG_EN defined, each segment output SHALL be registered from its digit, asserting one cycle after o_done.
REQ-026 With SIGNED_BCD_SEG_EN defined, o_seg_sign SHALL show segment g only when o_neg=1, and be blank otherwise.
REQ-027 Without SIGNED_BCD_SEG_EN, the segment ports and decoders SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-028 Shared package signed_calc_pkg SHALL hold the FSM state typedef, the BCD digit width constant (4), the digit count constant (3), and the 7-segment lookup constants.
REQ-029 One sub-module, bcd_to_7seg_v, SHALL be instantiated per digit, only under SIGNED_BCD_SEG_EN.

Verification
REQ-030 Reset then i_fs=0, start -> o_done in cycle 12; o_neg=0, digits 0/0/0.
REQ-031 i_fs=-225 -> o_neg=1, digits 2/2/5; and i_fs=-256 -> o_neg=1, digits 2/5/6.
REQ-032 i_fs=255, with i_start pulsed again at cycles 3 and 8 -> a single o_done, digits 2/5/5.
REQ-033 i_fs=3, with i_rst asserted in SHIFT cycle 5 -> no o_done, all outputs 0; a following start with i_fs=45 -> digits 0/4/5.
REQ-034 With SIGNED_BCD_SEG_EN defined, i_fs=-8 -> one cycle after o_done, o_seg_ones=7'b0000000, o_seg_sign=7'b0111111, o_seg_hund=7'b1000000.
